// File: rtl/gpr_multiport.sv
// gpr_multiport: clocked MIPS general-purpose register file.
// Features: NREAD combinational read ports with optional same-cycle write
// forwarding, a hardwired zero register, and overflow capture into OF_REG
// plus a sticky flag. A background engine clears registers 1..DEPTH-1, one
// per cycle.
//
// Clear handshake: a clr seen in IDLE starts the engine on the next edge.
// busy stays high for exactly DEPTH-1 cycles. clr_done pulses for one cycle
// after the last register is cleared. Writeback must stall while busy is
// high, because writes presented during a clear are dropped, not queued.
module gpr_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int OF_REG = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RegWrite,
    input  logic [ADDR_W-1:0]         WriteReg,
    input  logic [DATA_W-1:0]         WriteData,
    input  logic [NREAD*ADDR_W-1:0]   ReadReg,
    output logic [NREAD*DATA_W-1:0]   ReadData,
    input  logic                      OF,
    input  logic                      clr,
    output logic                      busy,
    output logic                      clr_done,
    output logic                      of_flag
);

    localparam int DEPTH = 1 << ADDR_W;

    // Index of the last register the clear engine touches (DEPTH-1).
    localparam logic [ADDR_W-1:0] LAST_IDX  = '1;
    // The clear engine starts at register 1; register 0 is never stored.
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    // Register that receives the value 1 on an overflow event.
    localparam logic [ADDR_W-1:0] OF_IDX    = ADDR_W'(OF_REG);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state;
    state_t              nextState;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   regs [DEPTH];

    logic                ofPrev;
    logic                ofEvent;
    logic                ofFlagQ;
    logic                clrDoneQ;

    logic                inClear;
    logic                startClear;
    logic                lastClear;
    logic                writeEn;
    logic                bypassOk;

    // ------------------------------------------------------------------
    // Clear engine FSM
    // ------------------------------------------------------------------

    // State register: reset always returns the engine to IDLE, even mid-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: one full pass over registers 1..DEPTH-1 per request.
    // A clr arriving during CLEAR is ignored; it does not restart the pass.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (clr) begin
                    nextState = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt == LAST_IDX) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Output decode: strobes that steer the array, counter and status flags.
    always_comb begin
        inClear    = (state == CLEAR);
        startClear = (state == IDLE) && clr;
        lastClear  = (state == CLEAR) && (cnt == LAST_IDX);
        // A write to register 0 is discarded, and so is any write during CLEAR.
        writeEn    = (state == IDLE) && RegWrite && (WriteReg != '0);
        // Forwarding is only meaningful while writes are actually accepted.
        bypassOk   = (BYPASS != 0) && (state == IDLE) && RegWrite;
    end

    // Clear counter: points at the register zeroed on the coming edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (startClear) begin
            cnt <= FIRST_IDX;
        end else if (inClear) begin
            // On the final step this wraps to 0. That is harmless because
            // the FSM returns to IDLE on the same edge.
            cnt <= cnt + ADDR_W'(1);
        end
    end

    // Completion pulse: high for exactly the cycle after the last clear step.
    always_ff @(posedge clk) begin
        if (rst) begin
            clrDoneQ <= 1'b0;
        end else begin
            clrDoneQ <= lastClear;
        end
    end

    // ------------------------------------------------------------------
    // Overflow capture
    // ------------------------------------------------------------------

    // OF history: an event is a low-to-high change seen across two edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            ofPrev <= 1'b0;
        end else begin
            ofPrev <= OF;
        end
    end

    assign ofEvent = OF && !ofPrev;

    // Sticky overflow flag: set by an event, dropped when a clear completes.
    // If an event lands on the completion edge itself, the event wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ofFlagQ <= 1'b0;
        end else if (ofEvent) begin
            ofFlagQ <= 1'b1;
        end else if (lastClear) begin
            ofFlagQ <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------

    // Array update. Later statements take priority: a normal write first,
    // then the clear step, then the overflow value, which beats both.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (writeEn) begin
                regs[WriteReg] <= WriteData;
            end
            if (inClear) begin
                regs[cnt] <= '0;
            end
            if (ofEvent) begin
                regs[OF_IDX] <= DATA_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [ADDR_W-1:0] rdAddr;
        logic [DATA_W-1:0] rdVal;

        assign rdAddr = ReadReg[k*ADDR_W +: ADDR_W];

        // Port k read mux. Register 0 always reads as zero. Otherwise a
        // matching accepted write is forwarded; failing that, the stored
        // value is returned.
        always_comb begin
            rdVal = regs[rdAddr];
            if (rdAddr == '0) begin
                rdVal = '0;
            end else if (bypassOk && (WriteReg == rdAddr)) begin
                rdVal = WriteData;
            end
        end

        assign ReadData[k*DATA_W +: DATA_W] = rdVal;
    end

    assign busy     = inClear;
    assign clr_done = clrDoneQ;
    assign of_flag  = ofFlagQ;

endmodule

// File: tb/tb_gpr_multiport.sv
// Testbench for gpr_multiport. The driver pushes expected values into a
// queue; a monitor on the falling edge pops the queue and compares.
// dut uses BYPASS=1 and dut_nb uses BYPASS=0. Both instances share every
// input.
module tb_gpr_multiport;

  localparam int W = 32;

  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [9:0]  ReadReg;
  logic [63:0] ReadData;
  logic [63:0] nb_read_data;
  logic        OF;
  logic        clr;
  logic        busy;
  logic        clr_done;
  logic        of_flag;
  logic        nb_busy;
  logic        nb_clr_done;
  logic        nb_of_flag;

  logic [W-1:0] exp_q[$];
  int           kind_q[$];
  int           checks = 0;
  int           errors = 0;

  gpr_multiport #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(1), .OF_REG(30)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg(ReadReg), .ReadData(ReadData), .OF(OF),
    .clr(clr), .busy(busy), .clr_done(clr_done), .of_flag(of_flag)
  );

  gpr_multiport #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(0), .OF_REG(30)) dut_nb (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg(ReadReg), .ReadData(nb_read_data), .OF(OF),
    .clr(clr), .busy(nb_busy), .clr_done(nb_clr_done), .of_flag(nb_of_flag)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic string kname(input int k);
    case (k)
      0: return "rd0";
      1: return "rd1";
      2: return "busy";
      3: return "clr_done";
      4: return "of_flag";
      5: return "nb_rd0";
      6: return "nb_rd1";
      7: return "nb_status";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: compare every queued expectation against the outputs held this cycle.
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;
  int           mon_kind;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_kind = kind_q.pop_front();
      case (mon_kind)
        0: mon_act = ReadData[31:0];
        1: mon_act = ReadData[63:32];
        2: mon_act = {31'b0, busy};
        3: mon_act = {31'b0, clr_done};
        4: mon_act = {31'b0, of_flag};
        5: mon_act = nb_read_data[31:0];
        6: mon_act = nb_read_data[63:32];
        7: mon_act = {29'b0, nb_busy, nb_clr_done, nb_of_flag};
        default: mon_act = 'x;
      endcase
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s @%0t: got %h expected %h", kname(mon_kind), $time, mon_act, mon_exp);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [W-1:0] v);
    exp_q.push_back(v);
    kind_q.push_back(k);
  endtask

  task automatic rd(input int a0, input logic [W-1:0] e0, input int a1, input logic [W-1:0] e1);
    ReadReg = {5'(a1), 5'(a0)};
    push(0, e0);
    push(1, e1);
    push(5, e0);
    push(6, e1);
  endtask

  task automatic status(input logic b, input logic d, input logic f);
    push(2, {31'b0, b});
    push(3, {31'b0, d});
    push(4, {31'b0, f});
  endtask

  task automatic write_reg(input int a, input logic [W-1:0] v);
    RegWrite  = 1'b1;
    WriteReg  = 5'(a);
    WriteData = v;
    tick();
    RegWrite  = 1'b0;
  endtask

  // Contents during the first clear: registers hold their index. Register i
  // is zeroed at the end of clear cycle i. An OF event at the end of cycle 20
  // sets reg30 to 1 until it is cleared at the end of cycle 30.
  function automatic logic [W-1:0] exp_clear(input int i, input int c);
    logic [W-1:0] v;
    v = (c >= 1 && i < c) ? 32'd0 : 32'(i);
    if (i == 30 && c >= 21 && c <= 30) v = 32'd1;
    return v;
  endfunction

  initial begin
    rst = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg = '0; OF = 1'b0; clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // 1. Random contents, then reset: everything reads 0.
    for (int i = 1; i < 32; i++) write_reg(i, $urandom);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    status(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      rd(2*j, 32'd0, 2*j + 1, 32'd0);
      tick();
    end
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFF_FFFF;
    rd(0, 32'd0, 0, 32'd0);
    tick();
    RegWrite = 1'b0;
    rd(0, 32'd0, 0, 32'd0);
    tick();

    // 2. Same-cycle forwarding on both ports.
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEAD_BEEF;
    ReadReg = {5'd5, 5'd5};
    push(0, 32'hDEAD_BEEF); push(1, 32'hDEAD_BEEF);
    push(5, 32'd0);         push(6, 32'd0);
    tick();
    RegWrite = 1'b0;
    rd(5, 32'hDEAD_BEEF, 5, 32'hDEAD_BEEF);
    tick();

    // 3. OF high for 3 cycles, with a write to reg30 on the rising cycle.
    ReadReg = {5'd30, 5'd30};
    OF = 1'b1; RegWrite = 1'b1; WriteReg = 5'd30; WriteData = 32'h1234_5678;
    push(0, 32'h1234_5678); push(5, 32'd0);
    tick();
    WriteData = 32'h0000_AAAA;
    push(0, 32'h0000_AAAA); push(5, 32'd1); push(4, 32'd1);
    tick();
    RegWrite = 1'b0;
    push(0, 32'h0000_AAAA); push(5, 32'h0000_AAAA);
    tick();
    OF = 1'b0;
    push(0, 32'h0000_AAAA);
    tick();
    OF = 1'b1;
    push(0, 32'h0000_AAAA);
    tick();
    OF = 1'b0;
    push(0, 32'd1); push(5, 32'd1); push(7, 32'd1);
    tick();

    // 4. Full clear over registers holding their index.
    for (int i = 1; i < 32; i++) write_reg(i, 32'(i));
    for (int c = 0; c < 34; c++) begin
      automatic int a0 = 1;
      clr = (c == 0 || c == 15);
      OF  = (c == 20);
      RegWrite = 1'b0;
      if (c == 3)  begin RegWrite = 1'b1; WriteReg = 5'd7;  WriteData = 32'd77; end
      if (c == 25) begin RegWrite = 1'b1; WriteReg = 5'd20; WriteData = 32'h55; end
      if (c == 3)  a0 = 7;
      if (c == 10) a0 = 10;
      if (c == 21) a0 = 30;
      if (c == 25) a0 = 20;
      rd(a0, exp_clear(a0, c), 31, exp_clear(31, c));
      status(c >= 1 && c <= 31, c == 32, c < 32);
      tick();
    end
    clr = 1'b0; OF = 1'b0; RegWrite = 1'b0;
    for (int j = 0; j < 16; j++) begin
      rd(2*j, 32'd0, 2*j + 1, 32'd0);
      tick();
    end

    // 5. Reset during a clear, then an immediate write.
    for (int i = 1; i < 32; i++) write_reg(i, 32'(i + 100));
    for (int c = 0; c < 15; c++) begin
      clr = (c == 0);
      rst = (c == 12);
      RegWrite = 1'b0;
      if (c <= 12) begin
        rd(13, 32'd113, 31, 32'd131);
        status(c >= 1, 1'b0, 1'b0);
      end else if (c == 13) begin
        RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h33;
        ReadReg = {5'd31, 5'd3};
        push(0, 32'h33); push(5, 32'd0); push(1, 32'd0); push(6, 32'd0);
        status(1'b0, 1'b0, 1'b0);
      end else begin
        rd(13, 32'd0, 3, 32'h33);
      end
      tick();
    end
    rst = 1'b0; clr = 1'b0; RegWrite = 1'b0;
    for (int j = 0; j < 16; j++) begin
      rd(2*j, (2*j == 3) ? 32'h33 : 32'd0, 2*j + 1, (2*j + 1 == 3) ? 32'h33 : 32'd0);
      tick();
    end

    // 6. clr held for 40 cycles: two back-to-back clears.
    for (int c = 0; c < 67; c++) begin
      clr = (c < 40);
      status((c >= 1 && c <= 31) || (c >= 33 && c <= 63), c == 32 || c == 64, 1'b0);
      tick();
    end
    clr = 1'b0;
    push(7, 32'd0);
    tick();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpr_multiport.md
Name: gpr_multiport

Overview:
- Parametrised, fully clocked general-purpose register file for the MIPS datapath. Successor to the current asynchronous 32x32 GPR.
- Adds:
  - NREAD combinational read ports with optional write-through bypass.
  - Hardwired zero register.
  - Synchronous overflow-flag capture into a status register.
  - Multi-cycle background clear engine, started on command, with a busy/done handshake.
- Sits between decode (read addresses) and writeback (write port, ALU OF).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W.
- NREAD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.
- OF_REG, 30, index written with 1 on an overflow event (must be nonzero).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- RegWrite  in  1  write enable.
- WriteReg  in  ADDR_W  write address.
- WriteData  in  DATA_W  write data.
- ReadReg  in  NREAD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- ReadData  out  NREAD*DATA_W  read data; port k = bits [k*DATA_W +: DATA_W].
- OF  in  1  ALU overflow level from execute.
- clr  in  1  request background clear (single-cycle pulse or level).
- busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse when clear completes.
- of_flag  out  1  sticky: an overflow event has occurred since last rst/clear.

Behaviour:
- Reset (rst=1 at a clk edge): all DEPTH registers <= 0; FSM <= IDLE; busy=0, clr_done=0, of_flag=0; internal OF history <= 0. Overrides every other input that cycle, including mid-clear.
- Register 0: always reads 0; writes to 0 are discarded; never stored nonzero.
- Read (combinational, 0 latency): ReadData[k] = reg[ReadReg[k]].
  - BYPASS=1, FSM=IDLE, RegWrite=1, WriteReg==ReadReg[k]!=0: ReadData[k] = WriteData.
  - BYPASS=0: the new value is visible the cycle after the write edge.
- Write: at the edge, if RegWrite=1, WriteReg!=0, FSM=IDLE and rst=0, then reg[WriteReg] <= WriteData.
- Overflow event = OF rising edge, detected synchronously (OF=1 this edge, OF=0 previous edge). On the event:
  - reg[OF_REG] <= 1 (zero-extended to DATA_W) and of_flag <= 1.
  - Beats a same-cycle write to OF_REG.
  - Level-high OF does not retrigger.
- FSM states IDLE, CLEAR; 5-bit (ADDR_W) counter cnt.
  - IDLE: if clr=1 -> CLEAR, cnt <= 1, busy <= 1.
  - CLEAR: each cycle reg[cnt] <= 0, cnt <= cnt+1.
    - When cnt == DEPTH-1: clear that register -> IDLE, busy <= 0, clr_done <= 1 for one cycle, of_flag <= 0.
  - Clear duration: exactly DEPTH-1 cycles of busy=1 (31 for defaults).
  - clr asserted while in CLEAR: ignored, no restart.
  - clr held high: a new clear starts the cycle after returning to IDLE.
- During CLEAR:
  - RegWrite is dropped, not queued. Writeback must stall on busy.
  - Reads return current array contents: registers not yet cleared keep old values. Bypass is disabled.
  - An overflow event in CLEAR: still sets of_flag and writes OF_REG. If cnt has not yet reached OF_REG, the clear later zeroes that register. of_flag is cleared at completion.
- clr_done is 0 in all cycles other than the completion pulse.
- Width: writes store full DATA_W, no truncation or extension beyond the OF_REG rule.

Test Plan:
- rst=1 one edge with random prior contents -> all 32 reads 0, busy=0, of_flag=0; WriteReg=0, WriteData=FFFFFFFF, RegWrite=1 -> ReadReg=0 still reads 0.
- Write reg5=DEADBEEF, same cycle ReadReg[0]=5:
  - BYPASS=1 -> ReadData[0]=DEADBEEF same cycle.
  - BYPASS=0 -> old value that cycle, DEADBEEF the next.
  - Both ports reading 5 match.
- OF 0->1 held 3 cycles, with a simultaneous write reg30=12345678 on the rising cycle -> reg30=00000001, of_flag=1. No second event until OF drops and rises again.
- Load regs 1..31 with index values, pulse clr:
  - busy=1 for exactly 31 cycles; clr_done pulses on the 32nd edge after the clr edge; all regs 0 after.
  - A RegWrite to reg7 mid-clear is lost (reg7=0 after).
  - Reading reg31 at cycle 10 returns 31.
- Assert rst at cycle 12 of a clear -> busy=0 and clr_done=0 next cycle; all regs 0; a following write to reg3 succeeds immediately.
- Hold clr=1 for 40 cycles -> two back-to-back clears: clr_done pulses twice, busy low for exactly one cycle between.
